// File: rtl/pcie_rx_cpld_pkg.sv
// Shared encodings for the RX completion tag buffer: per-tag lifecycle states
// and statistics counter widths.
package pcie_rx_cpld_pkg;

  typedef enum logic [1:0] {
    TAG_FREE        = 2'b00,
    TAG_OUTSTANDING = 2'b01,
    TAG_DONE        = 2'b10
  } tag_state_e;

  localparam int STAT_BEATS_W = 32;
  localparam int STAT_CPLDS_W = 16;

endpackage

// File: rtl/pcie_rx_cpld_fifo.sv
// Generic synchronous first-word-fall-through FIFO; the head word reads as zero
// while empty. Pointers carry an extra MSB so full and empty are distinguishable.
module pcie_rx_cpld_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [W-1:0]          wr_data,
  input  logic                  rd_en,
  output logic [W-1:0]          rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;

  logic [W-1:0]        mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                do_wr, do_rd;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);
  assign full  = (count == DEPTH);
  assign do_rd = rd_en & ~empty;
  // When full, a write is only safe if the head slot is freed on the same edge.
  assign do_wr = wr_en & (~full | do_rd);

  assign wr_ptr_d = wr_ptr_q + (DEPTH_LOG2+1)'(do_wr);
  assign rd_ptr_d = rd_ptr_q + (DEPTH_LOG2+1)'(do_rd);
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/pcie_rx_cpld_tag_buf.sv
// Completion-channel consumer: owns a read-tag pool, buffers completion beats in
// a FWFT FIFO and recycles a tag once its final beat is popped.
// Optional statistics outputs are enabled with PCIE_RX_CPLD_STATS_EN.
module pcie_rx_cpld_tag_buf
  import pcie_rx_cpld_pkg::*;
#(
  parameter int         C_PCIE_DATA_WIDTH = 512,
  parameter int         P_NUM_TAGS        = 32,
  parameter logic [7:0] P_TAG_BASE        = 8'h00,
  parameter int         P_FIFO_DEPTH_LOG2 = 4
) (
  input  logic                         pcie_user_clk,
  input  logic                         pcie_user_rst_n,
  input  logic                         tag_alloc_req,
  output logic                         tag_alloc_gnt,
  output logic [7:0]                   tag_alloc_tag,
  input  logic [7:0]                   cpld_fifo_tag,
  input  logic                         cpld_fifo_tag_last,
  input  logic                         cpld_fifo_wr_en,
  input  logic [C_PCIE_DATA_WIDTH-1:0] cpld_fifo_wr_data,
  input  logic                         rd_en,
  output logic                         rd_empty,
  output logic [C_PCIE_DATA_WIDTH-1:0] rd_data,
  output logic [7:0]                   rd_tag,
  output logic                         rd_tag_last,
  output logic [P_FIFO_DEPTH_LOG2:0]   rd_count,
  output logic                         tag_release_valid,
  output logic [7:0]                   tag_release_tag,
  output logic                         err_unexp_tag,
  output logic                         err_overflow,
  input  logic                         err_clr
`ifdef PCIE_RX_CPLD_STATS_EN
  ,
  output logic [STAT_BEATS_W-1:0]      stat_beats,
  output logic [STAT_CPLDS_W-1:0]      stat_cplds
`endif
);

  localparam int FW = C_PCIE_DATA_WIDTH + 9;

  tag_state_e            tag_state_q [P_NUM_TAGS];
  tag_state_e            tag_state_d [P_NUM_TAGS];
  logic [P_NUM_TAGS-1:0] alloc_sel, wr_hit, rel_hit, outstanding;
  logic                  alloc_any;
  logic                  wr_valid, wr_accept, pop, release_now, fifo_full;
  logic                  unexp_now, ovf_now;
  logic                  err_unexp_q, err_unexp_d, err_ovf_q, err_ovf_d;
  logic                  rel_valid_q;
  logic [7:0]            rel_tag_q, rel_tag_d;
  logic [FW-1:0]         fifo_rd_data;

  // Lowest free index wins: scan downward so the last hit is the smallest.
  always_comb begin
    alloc_sel     = '0;
    alloc_any     = 1'b0;
    tag_alloc_tag = P_TAG_BASE;
    for (int i = P_NUM_TAGS-1; i >= 0; i--) begin
      if (tag_state_q[i] == TAG_FREE) begin
        alloc_sel     = '0;
        alloc_sel[i]  = 1'b1;
        alloc_any     = 1'b1;
        tag_alloc_tag = 8'(P_TAG_BASE + i);
      end
    end
  end
  assign tag_alloc_gnt = tag_alloc_req & alloc_any;

  always_comb begin
    wr_hit      = '0;
    rel_hit     = '0;
    outstanding = '0;
    for (int i = 0; i < P_NUM_TAGS; i++) begin
      wr_hit[i]      = (cpld_fifo_tag == 8'(P_TAG_BASE + i));
      rel_hit[i]     = (rd_tag == 8'(P_TAG_BASE + i));
      outstanding[i] = (tag_state_q[i] == TAG_OUTSTANDING);
    end
  end

  assign pop         = rd_en & ~rd_empty;
  assign release_now = pop & rd_tag_last;
  assign wr_valid    = cpld_fifo_wr_en & |(wr_hit & outstanding);
  assign unexp_now   = cpld_fifo_wr_en & ~wr_valid;
  assign ovf_now     = wr_valid & fifo_full & ~pop;
  assign wr_accept   = wr_valid & ~ovf_now;

  // Alloc, last-beat write and release always hit different tags, so no priority is needed.
  always_comb begin
    for (int i = 0; i < P_NUM_TAGS; i++) begin
      tag_state_d[i] = tag_state_q[i];
      if (tag_alloc_gnt && alloc_sel[i])                   tag_state_d[i] = TAG_OUTSTANDING;
      if (wr_accept && cpld_fifo_tag_last && wr_hit[i])    tag_state_d[i] = TAG_DONE;
      if (release_now && rel_hit[i])                       tag_state_d[i] = TAG_FREE;
    end
  end

  assign err_unexp_d = (err_unexp_q & ~err_clr) | unexp_now;
  assign err_ovf_d   = (err_ovf_q & ~err_clr) | ovf_now;
  assign rel_tag_d   = release_now ? rd_tag : rel_tag_q;

  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      for (int i = 0; i < P_NUM_TAGS; i++) tag_state_q[i] <= TAG_FREE;
      err_unexp_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      rel_valid_q <= 1'b0;
      rel_tag_q   <= '0;
    end else begin
      for (int i = 0; i < P_NUM_TAGS; i++) tag_state_q[i] <= tag_state_d[i];
      err_unexp_q <= err_unexp_d;
      err_ovf_q   <= err_ovf_d;
      rel_valid_q <= release_now;
      rel_tag_q   <= rel_tag_d;
    end
  end

  assign err_unexp_tag     = err_unexp_q;
  assign err_overflow      = err_ovf_q;
  assign tag_release_valid = rel_valid_q;
  assign tag_release_tag   = rel_tag_q;

  pcie_rx_cpld_fifo #(
    .W          (FW),
    .DEPTH_LOG2 (P_FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (pcie_user_clk),
    .rst_n   (pcie_user_rst_n),
    .wr_en   (wr_accept),
    .wr_data ({cpld_fifo_tag_last, cpld_fifo_tag, cpld_fifo_wr_data}),
    .rd_en   (rd_en),
    .rd_data (fifo_rd_data),
    .empty   (rd_empty),
    .full    (fifo_full),
    .count   (rd_count)
  );

  assign rd_tag_last = fifo_rd_data[FW-1];
  assign rd_tag      = fifo_rd_data[FW-2 -: 8];
  assign rd_data     = fifo_rd_data[C_PCIE_DATA_WIDTH-1:0];

`ifdef PCIE_RX_CPLD_STATS_EN
  logic [STAT_BEATS_W-1:0] stat_beats_q, stat_beats_d;
  logic [STAT_CPLDS_W-1:0] stat_cplds_q, stat_cplds_d;

  assign stat_beats_d = (wr_accept && !(&stat_beats_q)) ? stat_beats_q + 1'b1 : stat_beats_q;
  assign stat_cplds_d = (release_now && !(&stat_cplds_q)) ? stat_cplds_q + 1'b1 : stat_cplds_q;

  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      stat_beats_q <= '0;
      stat_cplds_q <= '0;
    end else begin
      stat_beats_q <= stat_beats_d;
      stat_cplds_q <= stat_cplds_d;
    end
  end

  assign stat_beats = stat_beats_q;
  assign stat_cplds = stat_cplds_q;
`endif

endmodule

// File: tb/tb_pcie_rx_cpld_tag_buf.sv
// Self-checking bench for pcie_rx_cpld_tag_buf: directed vector table, corner
// sequences and randomized traffic against a queue-based reference model.
module tb_pcie_rx_cpld_tag_buf;

  localparam int         DW    = 512;
  localparam int         NT    = 32;
  localparam logic [7:0] BASE  = 8'h00;
  localparam int         DL2   = 4;
  localparam int         DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tag_alloc_req;
  logic          tag_alloc_gnt;
  logic [7:0]    tag_alloc_tag;
  logic [7:0]    cpld_fifo_tag;
  logic          cpld_fifo_tag_last;
  logic          cpld_fifo_wr_en;
  logic [DW-1:0] cpld_fifo_wr_data;
  logic          rd_en;
  logic          rd_empty;
  logic [DW-1:0] rd_data;
  logic [7:0]    rd_tag;
  logic          rd_tag_last;
  logic [DL2:0]  rd_count;
  logic          tag_release_valid;
  logic [7:0]    tag_release_tag;
  logic          err_unexp_tag;
  logic          err_overflow;
  logic          err_clr;
`ifdef PCIE_RX_CPLD_STATS_EN
  logic [31:0]   stat_beats;
  logic [15:0]   stat_cplds;
`endif

  pcie_rx_cpld_tag_buf #(
    .C_PCIE_DATA_WIDTH (DW),
    .P_NUM_TAGS        (NT),
    .P_TAG_BASE        (BASE),
    .P_FIFO_DEPTH_LOG2 (DL2)
  ) dut (
    .pcie_user_clk      (clk),
    .pcie_user_rst_n    (rst_n),
    .tag_alloc_req      (tag_alloc_req),
    .tag_alloc_gnt      (tag_alloc_gnt),
    .tag_alloc_tag      (tag_alloc_tag),
    .cpld_fifo_tag      (cpld_fifo_tag),
    .cpld_fifo_tag_last (cpld_fifo_tag_last),
    .cpld_fifo_wr_en    (cpld_fifo_wr_en),
    .cpld_fifo_wr_data  (cpld_fifo_wr_data),
    .rd_en              (rd_en),
    .rd_empty           (rd_empty),
    .rd_data            (rd_data),
    .rd_tag             (rd_tag),
    .rd_tag_last        (rd_tag_last),
    .rd_count           (rd_count),
    .tag_release_valid  (tag_release_valid),
    .tag_release_tag    (tag_release_tag),
    .err_unexp_tag      (err_unexp_tag),
    .err_overflow       (err_overflow),
    .err_clr            (err_clr)
`ifdef PCIE_RX_CPLD_STATS_EN
    ,
    .stat_beats         (stat_beats),
    .stat_cplds         (stat_cplds)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] d;
    logic [7:0]    t;
    logic          l;
  } beat_t;

  localparam int M_FREE = 0, M_OUT = 1, M_DONE = 2;
  beat_t       mq[$];
  int          mst [NT];
  logic        m_eu, m_eo, m_rv;
  logic [7:0]  m_rt;
  int          m_beats, m_cplds;

  function automatic void m_reset();
    mq.delete();
    for (int i = 0; i < NT; i++) mst[i] = M_FREE;
    m_eu = 0; m_eo = 0; m_rv = 0; m_rt = 0;
    m_beats = 0; m_cplds = 0;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < NT; i++) if (mst[i] == M_FREE) return i;
    return -1;
  endfunction

  task automatic check_all();
    chk("rd_empty", rd_empty, mq.size() == 0);
    chk("rd_count", rd_count, mq.size());
    if (mq.size() > 0) begin
      chk("rd_tag", rd_tag, mq[0].t);
      chk("rd_tag_last", rd_tag_last, mq[0].l);
      chk_data("rd_data", rd_data, mq[0].d);
    end else begin
      chk("rd_tag_idle", rd_tag, 0);
      chk("rd_last_idle", rd_tag_last, 0);
      chk_data("rd_data_idle", rd_data, '0);
    end
    chk("rel_valid", tag_release_valid, m_rv);
    chk("rel_tag", tag_release_tag, m_rt);
    chk("err_unexp", err_unexp_tag, m_eu);
    chk("err_ovf", err_overflow, m_eo);
`ifdef PCIE_RX_CPLD_STATS_EN
    chk("stat_beats", stat_beats, m_beats);
    chk("stat_cplds", stat_cplds, m_cplds);
`endif
  endtask

  // One clock cycle: drive, check combinational alloc, clock, update model, check.
  task automatic cycle(input logic a, input logic w, input logic [7:0] t, input logic l,
                       input logic r, input logic c, input logic [DW-1:0] d);
    int    low, idx;
    logic  gnt, inr, valid, pop, ovf, unexp;
    beat_t b;
    tag_alloc_req = a; cpld_fifo_wr_en = w; cpld_fifo_tag = t;
    cpld_fifo_tag_last = l; rd_en = r; err_clr = c; cpld_fifo_wr_data = d;
    #1;
    low = m_lowest();
    gnt = a && (low >= 0);
    chk("alloc_gnt", tag_alloc_gnt, gnt);
    if (gnt) chk("alloc_tag", tag_alloc_tag, BASE + low);
    idx   = int'(t) - int'(BASE);
    inr   = (idx >= 0) && (idx < NT);
    valid = inr && (mst[inr ? idx : 0] == M_OUT);
    pop   = r && (mq.size() > 0);
    unexp = w && !valid;
    ovf   = w && valid && (mq.size() == DEPTH) && !pop;
    @(posedge clk); #1;
    m_rv = 0;
    if (pop) begin
      b = mq.pop_front();
      if (b.l) begin
        mst[int'(b.t) - int'(BASE)] = M_FREE;
        m_rv = 1; m_rt = b.t; m_cplds++;
      end
    end
    if (gnt) mst[low] = M_OUT;
    if (w && valid && !ovf) begin
      b.d = d; b.t = t; b.l = l;
      mq.push_back(b);
      m_beats++;
      if (l) mst[idx] = M_DONE;
    end
    if (c) begin m_eu = 0; m_eo = 0; end
    if (unexp) m_eu = 1;
    if (ovf) m_eo = 1;
    check_all();
  endtask

  task automatic idle(); cycle(0, 0, 0, 0, 0, 0, '0); endtask

  // Asynchronous reset between clock edges; outputs must clear before any edge.
  task automatic async_reset(input string name);
    #2;
    tag_alloc_req = 1;
    rst_n = 0;
    #1;
    chk({name, "_empty"}, rd_empty, 1);
    chk({name, "_count"}, rd_count, 0);
    chk({name, "_gnt"}, tag_alloc_gnt, 1);
    chk({name, "_atag"}, tag_alloc_tag, BASE);
    chk({name, "_relv"}, tag_release_valid, 0);
    chk({name, "_eu"}, err_unexp_tag, 0);
    chk({name, "_eo"}, err_overflow, 0);
`ifdef PCIE_RX_CPLD_STATS_EN
    chk({name, "_sbeats"}, stat_beats, 0);
    chk({name, "_scplds"}, stat_cplds, 0);
`endif
    m_reset();
    tag_alloc_req = 0; cpld_fifo_wr_en = 0; rd_en = 0; err_clr = 0;
    @(posedge clk); #1;
    rst_n = 1;
    idle();
  endtask

  typedef struct {
    logic       a, w;
    logic [7:0] t;
    logic       l, r, c;
    logic       eg;
    logic [7:0] eat;
    int         ecnt;
    logic       erv;
    logic [7:0] ert;
    logic       eeu;
  } vec_t;

  vec_t vt[16];

  initial begin
    rst_n = 0;
    tag_alloc_req = 0; cpld_fifo_wr_en = 0; cpld_fifo_tag = 0; cpld_fifo_tag_last = 0;
    cpld_fifo_wr_data = '0; rd_en = 0; err_clr = 0;
    m_reset();

    //           a  w  tag    l  r  c  eg eat   cnt rv ert   eu
    vt[0]  = '{1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 8'h00, 0};
    vt[1]  = '{0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0};
    vt[2]  = '{0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 2, 0, 8'h00, 0};
    vt[3]  = '{0, 1, 8'h00, 1, 0, 0, 0, 8'h00, 3, 0, 8'h00, 0};
    vt[4]  = '{0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 2, 0, 8'h00, 0};
    vt[5]  = '{0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 0};
    vt[6]  = '{0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1, 8'h00, 0};
    vt[7]  = '{1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 8'h00, 0};
    vt[8]  = '{0, 1, 8'h05, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1};
    vt[9]  = '{0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1};
    vt[10] = '{0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0};
    vt[11] = '{0, 1, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0};
    vt[12] = '{0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 1};
    vt[13] = '{0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 1, 8'h00, 0};
    vt[14] = '{0, 1, 8'h40, 0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 1};
    vt[15] = '{0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0};

    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;
    idle();

    // Directed table: alloc, 3-beat completion, release, unexpected tags, err_clr priority.
    for (int i = 0; i < 16; i++) begin
      tag_alloc_req = vt[i].a;
      #1;
      chk("tbl_gnt", tag_alloc_gnt, vt[i].eg);
      if (vt[i].eg) chk("tbl_atag", tag_alloc_tag, vt[i].eat);
      cycle(vt[i].a, vt[i].w, vt[i].t, vt[i].l, vt[i].r, vt[i].c, {16{32'hA5000000 | i}});
      chk("tbl_count", rd_count, vt[i].ecnt);
      chk("tbl_relv", tag_release_valid, vt[i].erv);
      if (vt[i].erv) chk("tbl_relt", tag_release_tag, vt[i].ert);
      chk("tbl_eu", err_unexp_tag, vt[i].eeu);
    end

    // Overflow: fill 16, drop a 17th, then a 17th with simultaneous pop is accepted.
    cycle(1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'h00, 0, 0, 0, {16{32'h0F000000 | i}});
    chk("ovf_full", rd_count, 16);
    cycle(0, 1, 8'h00, 0, 0, 0, {16{32'hDEAD0001}});
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_count", rd_count, 16);
    cycle(0, 1, 8'h00, 0, 1, 0, {16{32'hBEEF0002}});
    chk("ovf_pop_count", rd_count, 16);
    chk("ovf_sticky", err_overflow, 1);
    cycle(0, 0, 8'h00, 0, 0, 1, '0);
    chk("ovf_clr", err_overflow, 0);
    async_reset("rst_ovf");

    // Pool exhaustion and re-grant of a released tag.
    for (int i = 0; i < NT; i++) begin
      tag_alloc_req = 1; #1;
      chk("pool_order", tag_alloc_tag, BASE + i);
      cycle(1, 0, 0, 0, 0, 0, '0);
    end
    tag_alloc_req = 1; #1;
    chk("pool_exhaust", tag_alloc_gnt, 0);
    cycle(1, 1, 8'h07, 1, 0, 0, {16{32'h07070707}});
    cycle(0, 0, 0, 0, 1, 0, '0);
    chk("pool_rel7", tag_release_tag, 8'h07);
    tag_alloc_req = 1; #1;
    chk("pool_regrant7", tag_alloc_tag, 8'h07);
    cycle(1, 0, 0, 0, 0, 0, '0);
    async_reset("rst_pool");

    // Interleaved completions on tags 1 and 2; tag 0 stays outstanding.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, '0);
    cycle(0, 1, 8'h01, 0, 0, 0, {16{32'h11110000}});
    cycle(0, 1, 8'h02, 0, 0, 0, {16{32'h22220000}});
    cycle(0, 1, 8'h01, 1, 1, 0, {16{32'h11110001}});
    cycle(0, 1, 8'h02, 1, 1, 0, {16{32'h22220001}});
    cycle(0, 0, 0, 0, 1, 0, '0);
    chk("il_rel1", tag_release_tag, 8'h01);
    cycle(0, 0, 0, 0, 1, 0, '0);
    chk("il_rel2", tag_release_tag, 8'h02);
    idle();

    // Mid-burst reset with 5 beats queued and several tags outstanding.
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'h00, 0, 0, 0, {16{32'h55000000 | i}});
    chk("burst_count", rd_count, 5);
    async_reset("rst_burst");

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] t;
      t = ($urandom_range(0, 99) < 88) ? 8'($urandom_range(0, NT-1)) : 8'($urandom_range(NT, 255));
      cycle($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 60, t,
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 4,
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_rx_cpld_tag_buf.md
Name: pcie_rx_cpld_tag_buf

Overview:
Downstream consumer of one completion channel from the RX completion selector (cpldN_fifo_* outputs), e.g. the DMA read-data path.
- Owns a tag pool of P_NUM_TAGS read tags and tracks each tag's lifecycle.
- Buffers completion beats in a FWFT FIFO and drops/flags beats for unexpected tags.
- Returns a tag to the pool only after the consumer has popped its final beat.
- The upstream completion path has no back-pressure, so overflow is detected and flagged, never stalled.

Parameters:
C_PCIE_DATA_WIDTH, 512, completion data beat width
P_NUM_TAGS, 32, tags managed; power of 2, 2..64
P_TAG_BASE, 8'h00, first tag value; pool is P_TAG_BASE .. P_TAG_BASE+P_NUM_TAGS-1
P_FIFO_DEPTH_LOG2, 4, beat FIFO depth = 2**P_FIFO_DEPTH_LOG2

Ports:
pcie_user_clk  in  1  clock
pcie_user_rst_n  in  1  reset, asynchronous, active-low
tag_alloc_req  in  1  requester wants a tag this cycle
tag_alloc_gnt  out  1  combinational: tag_alloc_req & any tag FREE
tag_alloc_tag  out  8  lowest-index FREE tag + P_TAG_BASE; valid when tag_alloc_gnt
cpld_fifo_tag  in  8  tag of incoming beat
cpld_fifo_tag_last  in  1  final beat of this tag's request
cpld_fifo_wr_en  in  1  beat valid; cannot be stalled
cpld_fifo_wr_data  in  C_PCIE_DATA_WIDTH  beat payload
rd_en  in  1  pop head beat
rd_empty  out  1  FIFO empty
rd_data  out  C_PCIE_DATA_WIDTH  head beat (FWFT)
rd_tag  out  8  head beat tag
rd_tag_last  out  1  head beat is final beat of its tag
rd_count  out  P_FIFO_DEPTH_LOG2+1  beats held
tag_release_valid  out  1  registered pulse: tag returned to pool
tag_release_tag  out  8  returned tag
err_unexp_tag  out  1  sticky: beat dropped, tag not OUTSTANDING
err_overflow  out  1  sticky: beat dropped, FIFO full
err_clr  in  1  clears both sticky errors

Behaviour:
Reset values:
- All tags FREE; FIFO empty; rd_empty=1; rd_count=0.
- tag_release_valid=0, tag_release_tag=0; both errors 0.
- rd_data, rd_tag, rd_tag_last = 0 when empty.

Per-tag 2-bit state (registered): FREE -> OUTSTANDING -> DONE -> FREE.
- FREE -> OUTSTANDING: on the clock edge where tag_alloc_gnt=1.
- OUTSTANDING -> DONE: on an accepted write with cpld_fifo_tag_last=1.
- DONE -> FREE: on a pop (rd_en & ~rd_empty) of a beat with rd_tag_last=1.
- The DONE -> FREE pop also produces tag_release_valid=1 and tag_release_tag on the next cycle.

Write acceptance:
- Tag in range and state OUTSTANDING: beat is valid.
- Out-of-range tag, or state FREE or DONE: beat dropped, err_unexp_tag set next cycle.
- Valid beat while FIFO full and no simultaneous pop: beat dropped, err_overflow set, tag state unchanged.
- Full plus simultaneous pop: write accepted, rd_count unchanged.

FIFO:
- Write-to-read latency is 1 cycle: a beat accepted at edge N is visible at the head after edge N.
- rd_en while empty is ignored.
- Pointers wrap modulo depth; rd_count = wr_ptr - rd_ptr using an extra MSB.

Allocation:
- Uses registered state only, so a tag released at edge N is allocatable from cycle N+1 onward.
- Priority encoder: lowest free index wins.

Simultaneous events:
- Allocation, tag-last write and release-pop on different tags in the same cycle all take effect.
- err_clr and a new error in the same cycle: the error wins.

Reset mid-operation: everything returns to reset values immediately (async); in-flight beats are lost.

Optional Feature:
PCIE_RX_CPLD_STATS_EN
- Defined: adds outputs stat_beats (32b) and stat_cplds (16b).
  - stat_beats: saturating count of accepted beats.
  - stat_cplds: saturating count of tag releases.
  - Both cleared by reset only.
- Undefined: the ports are absent and no counter logic is instantiated.

Decomposition:
- Package pcie_rx_cpld_pkg: tag state encodings (FREE=2'b00, OUTSTANDING=2'b01, DONE=2'b10), stat counter widths.
- Sub-module pcie_rx_cpld_fifo: generic synchronous FWFT FIFO with width/depth parameters, full/empty/count.
- Tag state array, allocator and error logic stay in the top module.

Test Plan:
- Alloc + 3-beat completion: alloc -> tag 0x00 granted; 3 beats with last on the third; pop all three -> tag_release_valid pulse with tag 0x00 one cycle after the third pop; tag 0x00 re-granted on the following request.
- Unexpected tag: beat with tag 0x05 while it is FREE -> dropped, rd_count stays 0, err_unexp_tag=1 until err_clr; a beat after tag_last for a DONE tag is also dropped.
- Overflow: 16 beats with no pops, then a 17th -> rd_count=16, err_overflow=1; 17th beat with simultaneous rd_en -> accepted, count stays 16.
- Pool exhaustion: 32 allocs -> tags 0x00..0x1F granted in order; 33rd request -> tag_alloc_gnt=0; release tag 0x07 -> next grant returns 0x07.
- Interleave: tags 0x01 and 0x02 completions interleaved -> FIFO order preserved; each tag released only at its own last-beat pop.
- Async reset asserted mid-burst with 5 beats queued -> rd_empty=1, rd_count=0, all tags FREE immediately; with PCIE_RX_CPLD_STATS_EN defined, counters read 0.
